pipeline_stall_controller: RTL
==============================

# pipeline_stall_controller

Sequential interlock unit for the 5-stage pipeline. It sits alongside the FD/DX/XM/MW latches, next to the combinational forwarding/hazard unit. It handles the hazards forwarding cannot resolve:
- load-use stalls (bubble into DX),
- multi-cycle mul/div freeze with a start-pulse/ready handshake to the multdiv unit,
- branch/jump flush of FD and DX.

Its outputs drive the enable and nop-insert muxes of the PC, FD, DX and XM latches.

## Interface
Parameters:
- MD_TIMEOUT, 40, maximum BUSY cycles before a mul/div is force-completed.
- CNT_W, 6, width of the BUSY cycle counter; must satisfy 2^CNT_W > MD_TIMEOUT.

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- inFD  in  32  instruction in FD latch.
- inDX  in  32  instruction in DX latch.
- flush  in  1  branch taken / jump resolved in X this cycle.
- data_resultRDY  in  1  multdiv result valid.
- data_exception  in  1  multdiv exception, valid with data_resultRDY.
- ctrl_MULT  out  1  one-cycle start pulse for mul.
- ctrl_DIV  out  1  one-cycle start pulse for div.
- stallPC  out  1  hold the PC.
- stallFD  out  1  hold the FD latch.
- stallDX  out  1  hold the DX latch.
- nopFD  out  1  load a nop into FD.
- nopDX  out  1  load a nop into DX.
- nopXM  out  1  load a nop into XM.
- mdDone  out  1  XM latch captures the multdiv result this cycle.
- mdExc  out  1  with mdDone: data_exception, or timeout.

## Operation
Field decode uses the shared ISA fields:
- opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2].
- mul: opcode 00000, aluop 00110. div: opcode 00000, aluop 00111. lw: opcode 01000.

Register read set of the FD instruction:
- rs is read by ALU, addi, lw, sw, bne, blt.
- rt is read by ALU ops except sll/sra.
- rd is read by sw, bne, blt, jr.

Load-use hazard:
- Condition: DX is lw, DX.rd != 0, DX.rd matches any register in the FD read set, md FSM is IDLE, and flush=0.
- Response: stallPC=stallFD=1 and nopDX=1 for exactly one cycle.

Flush:
- When flush=1 and the md FSM is IDLE: nopFD=nopDX=1, no stalls.
- Flush overrides load-use.

md FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If DX is mul or div and flush=0: assert ctrl_MULT or ctrl_DIV this cycle, stallPC=stallFD=stallDX=1, nopXM=1, clear the counter, go to BUSY.
- BUSY:
  - Outputs: stallPC/FD/DX=1, nopXM=1.
  - Counter increments each cycle.
  - If data_resultRDY: go to DONE, latch data_exception into an exc register.
  - Else if counter == MD_TIMEOUT-1: go to DONE with exc=1.
  - data_resultRDY and timeout in the same cycle: ready wins, exc = data_exception.
- DONE:
  - Outputs: mdDone=1, mdExc=exc, all stalls 0, nopXM=0.
  - Go to IDLE; the mul/div leaves DX on this edge and is not restarted.
- flush is ignored outside IDLE; X holds the mul/div, so a flush cannot originate there.

## Timing
- Reset value: state IDLE, counter 0, exc 0.
- During reset all outputs are 0. Reset asserted mid-BUSY returns to IDLE on the next edge with no mdDone.
- ctrl_MULT/ctrl_DIV are combinational from IDLE plus DX decode, and are high for exactly one cycle per mul/div.
- Minimum mul/div occupancy of X is 3 cycles: start cycle, one BUSY cycle with ready, DONE.
- Load-use bubble costs exactly 1 cycle. Back-to-back lw-use pairs each stall 1 cycle.
- All other outputs are combinational from state and inputs. Only the FSM, counter, exc and the perf counters are registered.

## Configuration
- STALL_PERF_CNT_EN defined: adds output ports loadUseCount[31:0] and mdStallCount[31:0]. Each is a saturating counter of load-use stall cycles and BUSY cycles respectively, reset to 0.
- Not defined: those ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - opcode constants (OP_ALU, OP_LW, OP_SW, OP_BNE, OP_BLT, OP_JR, OP_ADDI),
  - aluop constants (ALU_MUL, ALU_DIV, ALU_SLL, ALU_SRA),
  - the md state enum,
  - field-slice constants.
- One sub-module: instr_read_set. It is combinational and, from a 32-bit instruction, returns readsRS/readsRT/readsRD plus the three register indices.

## Test plan
- lw r5 in DX, FD = add r6,r5,r2 -> stallPC=stallFD=nopDX=1 for 1 cycle, then 0.
- lw r0 in DX, FD = add r6,r0,r2 -> no stall.
- mul in DX, data_resultRDY after 16 BUSY cycles -> ctrl_MULT pulse 1 cycle, stalls high 17 cycles, then mdDone=1, mdExc=0 for 1 cycle.
- div in DX, data_resultRDY never rises, MD_TIMEOUT=40 -> DONE after 40 BUSY cycles with mdDone=1, mdExc=1.
- flush=1 with the load-use condition also true -> nopFD=nopDX=1, stallPC=0.
- reset low during BUSY -> next cycle IDLE, all outputs 0, no mdDone.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared ISA field positions, opcode/aluop constants and the mul/div FSM state
// type used by the pipeline interlock logic.
package pipeline_stall_controller_pkg;

   localparam int OPCODE_HI = 31;
   localparam int OPCODE_LO = 27;
   localparam int RD_HI     = 26;
   localparam int RD_LO     = 22;
   localparam int RS_HI     = 21;
   localparam int RS_LO     = 17;
   localparam int RT_HI     = 16;
   localparam int RT_LO     = 12;
   localparam int ALUOP_HI  = 6;
   localparam int ALUOP_LO  = 2;

   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_JR   = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_BLT  = 5'b00110;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;

   localparam logic [4:0] ALU_SLL = 5'b00100;
   localparam logic [4:0] ALU_SRA = 5'b00101;
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Bundle between the pipeline latches / multdiv unit (master) and the stall
// controller (slave).
interface pipeline_stall_controller_if;
   logic [31:0] inFD;
   logic [31:0] inDX;
   logic        flush;
   logic        data_resultRDY;
   logic        data_exception;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic        stallPC;
   logic        stallFD;
   logic        stallDX;
   logic        nopFD;
   logic        nopDX;
   logic        nopXM;
   logic        mdDone;
   logic        mdExc;

   modport master (
      output inFD, inDX, flush, data_resultRDY, data_exception,
      input  ctrl_MULT, ctrl_DIV, stallPC, stallFD, stallDX,
             nopFD, nopDX, nopXM, mdDone, mdExc
   );

   modport slave (
      input  inFD, inDX, flush, data_resultRDY, data_exception,
      output ctrl_MULT, ctrl_DIV, stallPC, stallFD, stallDX,
             nopFD, nopDX, nopXM, mdDone, mdExc
   );
endinterface

// File: rtl/pipeline_stall_controller_read_set.sv
// instr_read_set: combinational decode of which source registers an
// instruction reads, plus its rs/rt/rd indices.
module instr_read_set
   import pipeline_stall_controller_pkg::*;
(
   input  logic [31:0] instr,
   output logic        readsRS,
   output logic        readsRT,
   output logic        readsRD,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd
);

   logic [4:0] opcode;
   logic [4:0] aluop;
   logic       unused_instr_bits;

   assign opcode = instr[OPCODE_HI:OPCODE_LO];
   assign aluop  = instr[ALUOP_HI:ALUOP_LO];
   assign rs     = instr[RS_HI:RS_LO];
   assign rt     = instr[RT_HI:RT_LO];
   assign rd     = instr[RD_HI:RD_LO];
   assign unused_instr_bits = ^{instr[11:7], instr[1:0]};

   always_comb begin
      readsRS = 1'b0;
      readsRT = 1'b0;
      readsRD = 1'b0;
      case (opcode)
         OP_ALU: begin
            readsRS = 1'b1;
            // shifts carry a shamt where rt would be
            readsRT = !((aluop == ALU_SLL) || (aluop == ALU_SRA));
         end
         OP_ADDI, OP_LW: readsRS = 1'b1;
         OP_SW, OP_BNE, OP_BLT: begin
            readsRS = 1'b1;
            readsRD = 1'b1;
         end
         OP_JR:   readsRD = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline interlock: load-use bubble, mul/div freeze handshake, branch flush.
// Define STALL_PERF_CNT_EN to add the loadUseCount/mdStallCount perf ports.
module pipeline_stall_controller
   import pipeline_stall_controller_pkg::*;
#(
   parameter int MD_TIMEOUT = 40,
   parameter int CNT_W      = 6
) (
   input logic clock,
   input logic reset,
   pipeline_stall_controller_if.slave bus
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [31:0] loadUseCount,
   output logic [31:0] mdStallCount
`endif
);

   md_state_t        state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             exc_reg;

   logic [4:0] dx_opcode;
   logic [4:0] dx_rd;
   logic [4:0] dx_aluop;
   logic       dx_lw;
   logic       dx_mul;
   logic       dx_div;
   logic       unused_dx_bits;

   assign dx_opcode = bus.inDX[OPCODE_HI:OPCODE_LO];
   assign dx_rd     = bus.inDX[RD_HI:RD_LO];
   assign dx_aluop  = bus.inDX[ALUOP_HI:ALUOP_LO];
   assign dx_lw     = (dx_opcode == OP_LW);
   assign dx_mul    = (dx_opcode == OP_ALU) && (dx_aluop == ALU_MUL);
   assign dx_div    = (dx_opcode == OP_ALU) && (dx_aluop == ALU_DIV);
   assign unused_dx_bits = ^{bus.inDX[21:7], bus.inDX[1:0]};

   logic       fd_reads_rs;
   logic       fd_reads_rt;
   logic       fd_reads_rd;
   logic [4:0] fd_rs;
   logic [4:0] fd_rt;
   logic [4:0] fd_rd;

   instr_read_set u_fd_read_set (
      .instr   (bus.inFD),
      .readsRS (fd_reads_rs),
      .readsRT (fd_reads_rt),
      .readsRD (fd_reads_rd),
      .rs      (fd_rs),
      .rt      (fd_rt),
      .rd      (fd_rd)
   );

   logic [2:0] reads_vec;
   logic [4:0] idx_vec [3];
   logic [2:0] match_vec;

   assign reads_vec  = {fd_reads_rd, fd_reads_rt, fd_reads_rs};
   assign idx_vec[0] = fd_rs;
   assign idx_vec[1] = fd_rt;
   assign idx_vec[2] = fd_rd;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_match
         assign match_vec[gi] = reads_vec[gi] && (idx_vec[gi] == dx_rd);
      end
   endgenerate

   logic load_use_hazard;
   logic md_idle;
   logic load_use;
   logic flush_act;
   logic md_start;
   logic md_busy;
   logic md_done;
   logic timeout_hit;

   assign load_use_hazard = dx_lw && (dx_rd != 5'd0) && (|match_vec);

   // Every output is gated by reset so nothing leaks while it is held low,
   // even if the state register still shows BUSY on the first reset cycle.
   assign md_idle   = reset && (state_reg == MD_IDLE);
   assign md_busy   = reset && (state_reg == MD_BUSY);
   assign md_done   = reset && (state_reg == MD_DONE);
   assign flush_act = md_idle && bus.flush;
   assign load_use  = md_idle && !bus.flush && load_use_hazard;
   assign md_start  = md_idle && !bus.flush && (dx_mul || dx_div);

   assign timeout_hit = (cnt_reg == CNT_W'(MD_TIMEOUT - 1));

   assign bus.ctrl_MULT = md_start && dx_mul;
   assign bus.ctrl_DIV  = md_start && dx_div;
   assign bus.stallPC   = load_use || md_start || md_busy;
   assign bus.stallFD   = load_use || md_start || md_busy;
   assign bus.stallDX   = md_start || md_busy;
   assign bus.nopFD     = flush_act;
   assign bus.nopDX     = flush_act || load_use;
   assign bus.nopXM     = md_start || md_busy;
   assign bus.mdDone    = md_done;
   assign bus.mdExc     = md_done && exc_reg;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg <= MD_IDLE;
         cnt_reg   <= '0;
         exc_reg   <= 1'b0;
      end else begin
         case (state_reg)
            MD_IDLE: begin
               if (md_start) begin
                  state_reg <= MD_BUSY;
                  cnt_reg   <= '0;
               end
            end
            MD_BUSY: begin
               cnt_reg <= cnt_reg + 1'b1;
               // a result arriving on the timeout cycle still counts as a result
               if (bus.data_resultRDY) begin
                  state_reg <= MD_DONE;
                  exc_reg   <= bus.data_exception;
               end else if (timeout_hit) begin
                  state_reg <= MD_DONE;
                  exc_reg   <= 1'b1;
               end
            end
            MD_DONE: state_reg <= MD_IDLE;
            default: state_reg <= MD_IDLE;
         endcase
      end
   end

`ifdef STALL_PERF_CNT_EN
   logic [31:0] load_use_count_reg;
   logic [31:0] md_stall_count_reg;

   always_ff @(posedge clock) begin
      if (!reset) begin
         load_use_count_reg <= '0;
         md_stall_count_reg <= '0;
      end else begin
         if (load_use && (load_use_count_reg != '1))
            load_use_count_reg <= load_use_count_reg + 32'd1;
         if (md_busy && (md_stall_count_reg != '1))
            md_stall_count_reg <= md_stall_count_reg + 32'd1;
      end
   end

   assign loadUseCount = load_use_count_reg;
   assign mdStallCount = md_stall_count_reg;
`endif

endmodule
